// File: rtl/column_window_gen.sv
// rtl/column_window_gen.sv - vertical 3-pixel column window over a raster stream
// Two line buffers shift each column down one row per accepted pixel to present rows y-2, y-1 and y.
module column_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic [DATA_W-1:0] C_out,
  output logic              col_valid,
  output logic [COL_W-1:0]  col_x,
  output logic              line_last
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];

  logic [COL_W-1:0]  cx;
  logic [ROW_W-1:0]  cy;

  logic [COL_W-1:0]  eff_cx;
  logic [ROW_W-1:0]  eff_cy;
  logic [AW-1:0]     rd_addr;
  logic              at_last;
  logic              row_ok;
  logic [COL_W-1:0]  nxt_cx;
  logic [ROW_W-1:0]  nxt_cy;
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;

  // sof with a pixel makes that pixel (row 0, column 0) of the new frame
  always_comb begin
    eff_cx  = sof ? '0 : cx;
    eff_cy  = sof ? '0 : cy;
    rd_addr = eff_cx[AW-1:0];
    at_last = (eff_cx == LAST_COL);
    row_ok  = (eff_cy >= ROW_TWO);
    lb1_rd  = lb1[rd_addr];
    lb2_rd  = lb2[rd_addr];
  end

  always_comb begin
    nxt_cx = eff_cx + COL_W'(1);
    nxt_cy = eff_cy;
    if (at_last) begin
      nxt_cx = '0;
      nxt_cy = (eff_cy == ROW_MAX) ? eff_cy : eff_cy + ROW_W'(1);
    end
  end

  // Buffer storage is deliberately unreset; rows 0 and 1 mask stale contents
  always_ff @(posedge clk) begin
    if (rst_n && pix_valid) begin
      lb2[rd_addr] <= lb1_rd;
      lb1[rd_addr] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_out     <= '0;
      B_out     <= '0;
      C_out     <= '0;
      col_x     <= '0;
      col_valid <= 1'b0;
      line_last <= 1'b0;
      cx        <= '0;
      cy        <= '0;
    end else if (pix_valid) begin
      A_out     <= lb2_rd;
      B_out     <= lb1_rd;
      C_out     <= pix_in;
      col_x     <= eff_cx;
      col_valid <= row_ok;
      line_last <= row_ok && at_last;
      cx        <= nxt_cx;
      cy        <= nxt_cy;
    end else begin
      col_valid <= 1'b0;
      line_last <= 1'b0;
      if (sof) begin
        cx <= '0;
        cy <= '0;
      end
    end
  end

endmodule

// File: tb/tb_column_window_gen.sv
// tb/tb_column_window_gen.sv - scoreboard bench for column_window_gen
// Reference model stores every line of the current frame and predicts triples from line indices.
module tb_column_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int CW = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sof = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic [DW-1:0] A_out, B_out, C_out;
  logic          col_valid, line_last;
  logic [CW-1:0] col_x;

  column_window_gen #(.DATA_W(DW), .IMG_W(W), .COL_W(CW), .ROW_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .pix_in(pix_in), .pix_valid(pix_valid),
    .A_out(A_out), .B_out(B_out), .C_out(C_out), .col_valid(col_valid),
    .col_x(col_x), .line_last(line_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [CW-1:0] x;
    logic          last;
  } exp_t;

  exp_t          q[$];
  exp_t          e_mon;
  logic [DW-1:0] frame [64][W];
  int            mrow = 0;
  int            mcol = 0;
  int            total = 0;
  int            bad = 0;
  int            pulses = 0;
  int            pushes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge
  logic          last_acc = 1'b0;
  logic [DW-1:0] pa = '0, pb = '0, pc = '0;
  logic [CW-1:0] px = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {A_out, B_out, C_out, col_x, col_valid, line_last}, 32'h0);
      last_acc = 1'b0;
    end else begin
      if (col_valid) begin
        pulses++;
        if (q.size() == 0) begin
          chk("unexpected_col_valid_queue", q.size(), 1);
        end else begin
          e_mon = q.pop_front();
          chk("A_out", A_out, e_mon.a);
          chk("B_out", B_out, e_mon.b);
          chk("C_out", C_out, e_mon.c);
          chk("col_x", col_x, e_mon.x);
          chk("line_last", line_last, e_mon.last);
        end
      end else begin
        chk("line_last_idle", line_last, 0);
      end
      if (!last_acc)
        chk("hold_outputs", {A_out, B_out, C_out, col_x}, {pa, pb, pc, px});
      last_acc = pix_valid;
    end
    pa = A_out; pb = B_out; pc = C_out; px = col_x;
  end

  task automatic send(input logic [DW-1:0] p, input logic s);
    exp_t e;
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_in = p; sof = s;
    if (s) begin mrow = 0; mcol = 0; end
    frame[mrow][mcol] = p;
    if (mrow >= 2) begin
      e.a = frame[mrow-2][mcol];
      e.b = frame[mrow-1][mcol];
      e.c = p;
      e.x = CW'(mcol);
      e.last = (mcol == W - 1);
      q.push_back(e);
      pushes++;
    end
    mcol++;
    if (mcol == W) begin mcol = 0; mrow++; end
  endtask

  task automatic idle(input logic s);
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = s; pix_in = DW'($urandom);
    if (s) begin mrow = 0; mcol = 0; end
  endtask

  task automatic flush();
    idle(0); idle(0);
  endtask

  initial begin
    #2 rst_n = 1'b0; pix_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1 pix_in = DW'($urandom); end
    @(posedge clk); #1 rst_n = 1'b1; pix_valid = 1'b0;
    mrow = 0; mcol = 0; q.delete();

    // continuous frame straight out of reset
    for (int i = 0; i < 3 * W; i++) send(DW'(16 * (i / W) + i % W), 1'b0);
    flush();
    chk("pulses_continuous", pulses, 4);
    pulses = 0;

    // gapped row 2 then sliding row 3
    idle(1);
    for (int i = 0; i < 2 * W; i++) send(DW'(16 * (i / W) + i % W), 1'b0);
    for (int c = 0; c < W; c++) begin
      send(DW'(16 * 2 + c), 1'b0);
      repeat (3) idle(0);
    end
    for (int c = 0; c < W; c++) send(DW'(16 * 3 + c), 1'b0);
    flush();
    chk("pulses_gapped", pulses, 8);
    pulses = 0;

    // sof with pixel mid-frame at row 2 col 2
    send(8'h00, 1'b1);
    for (int i = 1; i < 2 * W + 2; i++) send(DW'(16 * (i / W) + i % W), 1'b0);
    send(8'h00, 1'b1);
    for (int i = 1; i < 3 * W; i++) send(DW'(16 * (i / W) + i % W), 1'b0);
    flush();
    chk("pulses_sof_midframe", pulses, 6);
    pulses = 0;

    // asynchronous reset between clock edges during row 3
    idle(1);
    for (int i = 0; i < 3 * W + 2; i++) send(DW'(16 * (i / W) + i % W), 1'b0);
    idle(0);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 chk("async_reset_immediate", {A_out, B_out, C_out, col_x, col_valid, line_last}, 32'h0);
    q.delete(); mrow = 0; mcol = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3 * W; i++) send(DW'(16 * (i / W) + i % W), 1'b0);
    flush();
    chk("pulses_async_reset", pulses, 10);
    pulses = 0;

    // random pixels and gaps; long frame drives the row counter into saturation
    begin
      int sof_at;
      sof_at = $urandom_range(100, 140);
      pushes = 0;
      idle(1);
      for (int i = 0; i < 240; i++) begin
        send(DW'($urandom), (i == sof_at));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle(0);
      end
      flush();
      chk("pulses_random", pulses, pushes);
    end
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
